mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 62 ++++++
 rtl/mem_access_if.sv | 28 ++
 rtl/define.sv | 8 +
 rtl/mem_lane_align.sv | 17 +
 rtl/mem_access_unit.sv | 129 ++++++++++++
 tb/tb_mem_access_unit.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the memory access unit.
// Holds size encodings, the FSM state enum, the misalignment check and the
// little-endian lane extract / merge functions.
`include "define.sv"

package mem_access_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        RESP
    } state_e;

    // Size 11 is never legal, so it is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_B:  r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SIZE_H:  r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] off, input logic [1:0] size);
        logic [31:0] r;
        r = word;
        case (size)
            SIZE_B: r[{off, 3'b000} +: 8] = wdata[7:0];
            SIZE_H: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response bundle between a requester (master) and the memory
// access unit (slave).
//   req_*  : request fields, qualified by req_valid && req_ready
//   resp_* : one-cycle completion pulse plus load data / misalignment flag
`include "define.sv"

interface mem_access_if #(parameter int ADDR_W = `RAM_ADDRESS_BITWIDTH);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misaligned;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned
    );
endinterface

// File: rtl/define.sv
// Global RAM geometry shared by the memory access path and its users.
//   RAM_ADDRESS_BITWIDTH : byte-address width of the data RAM
//   RAM_SIZE             : RAM size in bytes
`ifndef DEFINE_SV
`define DEFINE_SV
`define RAM_ADDRESS_BITWIDTH 16
`define RAM_SIZE             65536
`endif

// File: rtl/mem_lane_align.sv
// Combinational lane alignment.
//   rdata/off/size/uns -> ext_data  : load result extracted from the RAM word
//   rdata/wdata/off/size -> mrg_data: RAM word with the addressed lanes replaced
import mem_access_pkg::*;

module mem_lane_align (
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] ext_data,
    output logic [31:0] mrg_data
);
    assign ext_data = lane_extract(rdata, off, size, uns);
    assign mrg_data = lane_merge(rdata, wdata, off, size);
endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit in front of a word-wide RAM with a two-cycle
// read path. Sub-word stores are read-modify-write.
//   clk, rstn      : clock, asynchronous active-low reset
//   req_if         : request/response handshake (slave side)
//   mem_wren       : RAM write enable, high only in WRITE
//   mem_address    : registered, word-aligned RAM byte address
//   mem_write_data : registered full-word store data
//   mem_data       : RAM read data
`include "define.sv"
import mem_access_pkg::*;

module mem_access_unit #(
    parameter int ADDR_W = `RAM_ADDRESS_BITWIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    mem_access_if.slave       req_if,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_data
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic              mis_q, mis_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Holds the raw store data from accept until MERGE, then the merged word.
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       ext_data;
    logic [31:0]       mrg_data;

    mem_lane_align u_align (
        .rdata    (mem_data),
        .wdata    (wdata_q),
        .off      (off_q),
        .size     (size_q),
        .uns      (uns_q),
        .ext_data (ext_data),
        .mrg_data (mrg_data)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_if.req_valid) begin
                    we_d   = req_if.req_we;
                    size_d = req_if.req_size;
                    uns_d  = req_if.req_unsigned;
                    off_d  = req_if.req_addr[1:0];
                    mis_d  = is_misaligned(req_if.req_size, req_if.req_addr[1:0]);
                    if (mis_d) begin
                        // Rejected access: straight to RESP, RAM untouched.
                        rdata_d = 32'd0;
                        state_d = RESP;
                    end else begin
                        addr_d = {req_if.req_addr[ADDR_W-1:2], 2'b00};
                        if (req_if.req_we) wdata_d = req_if.req_wdata;
                        state_d = (req_if.req_we && req_if.req_size == SIZE_W) ? WRITE : READ;
                    end
                end
            end
            READ:  state_d = MERGE;
            MERGE: begin
                if (we_q) begin
                    wdata_d = mrg_data;
                    state_d = WRITE;
                end else begin
                    rdata_d = ext_data;
                    state_d = RESP;
                end
            end
            WRITE: begin
                rdata_d = 32'd0;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SIZE_B;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Ready is gated by rstn so it reads 0 while reset is held.
    assign req_if.req_ready       = rstn && (state_q == IDLE);
    assign req_if.resp_valid      = (state_q == RESP);
    assign req_if.resp_misaligned = (state_q == RESP) && mis_q;
    assign req_if.resp_rdata      = rdata_q;
    assign mem_wren               = (state_q == WRITE);
    assign mem_address            = addr_q;
    assign mem_write_data         = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a two-cycle-latency RAM model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_wren;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_data;

    logic [31:0] ram [0:255];
    logic [15:0] rd_addr_q = 16'd0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_if #(.ADDR_W(16)) bus ();

    mem_access_unit #(.ADDR_W(16)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_if         (bus.slave),
        .mem_wren       (mem_wren),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_data       (mem_data)
    );

    always #5 clk = ~clk;

    // Registered address, combinational array read: data follows the cycle after the address.
    always @(posedge clk) begin
        rd_addr_q <= mem_address;
        if (mem_wren) ram[mem_address[9:2]] <= mem_write_data;
    end
    assign mem_data = ram[rd_addr_q[9:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request from IDLE and watches 8 cycles. k=1 is the cycle after
    // the accepting edge (T+1).
    task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wd,
                          output int rk, output logic [31:0] rd, output logic mis,
                          output int nr, output int nw, output int wk);
        rk = -1; rd = 32'hx; mis = 1'bx; nr = 0; nw = 0; wk = -1;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_wren) begin nw++; wk = k; end
            if (bus.resp_valid) begin
                nr++; rk = k; rd = bus.resp_rdata; mis = bus.resp_misaligned;
            end
        end
    endtask

    initial begin
        int rk, nr, nw, wk, nrdy, r1k, r2k, nresp;
        logic [31:0] rd, r1d, r2d;
        logic mis, b_taken;

        for (int i = 0; i < 256; i++) ram[i] = 32'd0;
        ram[8'h04] = 32'h8899AABB;   // 0x10
        ram[8'h08] = 32'h11223380;   // 0x20
        ram[8'h0C] = 32'hAABBCCDD;   // 0x30
        ram[8'h14] = 32'hDEADBEEF;   // 0x50
        ram[8'h18] = 32'h00000000;   // 0x60
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 16'd0; bus.req_wdata = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mis", {31'd0, bus.resp_misaligned}, 32'd0);
        chk("rst_wren", {31'd0, mem_wren}, 32'd0);
        chk("rst_addr", {16'd0, mem_address}, 32'd0);
        chk("rst_wdata", mem_write_data, 32'd0);
        rstn = 1'b1;
        #1 chk("rel_ready", {31'd0, bus.req_ready}, 32'd1);

        // LW 0x10
        run_op(1'b0, 2'b10, 1'b0, 16'h0010, 32'd0, rk, rd, mis, nr, nw, wk);
        chk("lw_resp_cycle", rk, 3);
        chk("lw_resp_count", nr, 1);
        chk("lw_rdata", rd, 32'h8899AABB);
        chk("lw_mis", {31'd0, mis}, 32'd0);
        chk("lw_wren_count", nw, 0);

        // LB / LBU / LH / LBU of upper byte
        run_op(1'b0, 2'b00, 1'b0, 16'h0020, 32'd0, rk, rd, mis, nr, nw, wk);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        chk("lb_resp_cycle", rk, 3);
        run_op(1'b0, 2'b00, 1'b1, 16'h0020, 32'd0, rk, rd, mis, nr, nw, wk);
        chk("lbu_rdata", rd, 32'h00000080);
        run_op(1'b0, 2'b01, 1'b0, 16'h0022, 32'd0, rk, rd, mis, nr, nw, wk);
        chk("lh_rdata", rd, 32'h00001122);
        run_op(1'b0, 2'b01, 1'b0, 16'h0030, 32'd0, rk, rd, mis, nr, nw, wk);
        chk("lh_neg_rdata", rd, 32'hFFFFCCDD);
        run_op(1'b0, 2'b00, 1'b1, 16'h0013, 32'd0, rk, rd, mis, nr, nw, wk);
        chk("lbu_b3_rdata", rd, 32'h00000088);

        // SB 0x31 <- 0x55
        run_op(1'b1, 2'b00, 1'b0, 16'h0031, 32'h12345655, rk, rd, mis, nr, nw, wk);
        chk("sb_wren_count", nw, 1);
        chk("sb_wren_cycle", wk, 3);
        chk("sb_resp_cycle", rk, 4);
        chk("sb_rdata", rd, 32'd0);
        chk("sb_ram", ram[8'h0C], 32'hAABB55DD);

        // SW 0x60 and SH 0x62
        run_op(1'b1, 2'b10, 1'b0, 16'h0060, 32'hCAFEF00D, rk, rd, mis, nr, nw, wk);
        chk("sw_wren_cycle", wk, 1);
        chk("sw_resp_cycle", rk, 2);
        chk("sw_ram", ram[8'h18], 32'hCAFEF00D);
        run_op(1'b1, 2'b01, 1'b0, 16'h0062, 32'h0000BEEF, rk, rd, mis, nr, nw, wk);
        chk("sh_ram", ram[8'h18], 32'hBEEFF00D);

        // Misaligned: SW 0x41, LH 0x43, illegal size
        run_op(1'b1, 2'b10, 1'b0, 16'h0041, 32'hFFFFFFFF, rk, rd, mis, nr, nw, wk);
        chk("sw_mis_cycle", rk, 1);
        chk("sw_mis_flag", {31'd0, mis}, 32'd1);
        chk("sw_mis_rdata", rd, 32'd0);
        chk("sw_mis_wren", nw, 0);
        chk("sw_mis_ram", ram[8'h10], 32'd0);
        run_op(1'b0, 2'b01, 1'b0, 16'h0043, 32'd0, rk, rd, mis, nr, nw, wk);
        chk("lh_mis_cycle", rk, 1);
        chk("lh_mis_flag", {31'd0, mis}, 32'd1);
        chk("lh_mis_rdata", rd, 32'd0);
        run_op(1'b0, 2'b11, 1'b0, 16'h0010, 32'd0, rk, rd, mis, nr, nw, wk);
        chk("sz11_mis_flag", {31'd0, mis}, 32'd1);
        #1 chk("mis_idle_flag", {31'd0, bus.resp_misaligned}, 32'd0);

        // Reset in MERGE of SH 0x50
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b01;
        bus.req_unsigned = 1'b0; bus.req_addr = 16'h0050; bus.req_wdata = 32'h00001234;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);   // READ
        @(negedge clk);   // MERGE
        rstn = 1'b0;
        #1;
        chk("rstmid_wren", {31'd0, mem_wren}, 32'd0);
        chk("rstmid_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rstmid_addr", {16'd0, mem_address}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        nr = 0; nw = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.resp_valid) nr++;
            if (mem_wren) nw++;
        end
        chk("rstmid_resp", nr, 0);
        chk("rstmid_wren_cnt", nw, 0);
        chk("rstmid_ram", ram[8'h14], 32'hDEADBEEF);
        chk("rstmid_ready_after", {31'd0, bus.req_ready}, 32'd1);
        run_op(1'b0, 2'b10, 1'b0, 16'h0050, 32'd0, rk, rd, mis, nr, nw, wk);
        chk("post_rst_lw", rd, 32'hDEADBEEF);

        // Busy: LW 0x10 then LW 0x20 held valid back to back
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 16'h0010;
        @(posedge clk);
        #1 bus.req_addr = 16'h0020;
        b_taken = 1'b0; nrdy = 0; nresp = 0; nw = 0;
        r1k = -1; r2k = -1; r1d = 32'd0; r2d = 32'd0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (mem_wren) nw++;
            if (bus.resp_valid) begin
                nresp++;
                if (nresp == 1) begin r1k = k; r1d = bus.resp_rdata; end
                else begin r2k = k; r2d = bus.resp_rdata; end
            end
            if (bus.req_ready && !b_taken) begin
                nrdy = k;
                b_taken = 1'b1;
                @(posedge clk);
                #1 bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        chk("busy_resp_count", nresp, 2);
        chk("busy_first_cycle", r1k, 3);
        chk("busy_first_rdata", r1d, 32'h8899AABB);
        chk("busy_ready_cycle", nrdy, 4);
        chk("busy_second_cycle", r2k, 7);
        chk("busy_second_rdata", r2d, 32'h11223380);
        chk("busy_wren", nw, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
